dmem_handshake: RTL and testbench
=================================

# dmem_handshake

Parametrised, handshake-based data memory for the RISC-V datapath, sitting between the ALU/LSU stage and write-back. It generalises the single-cycle data memory with the following features:
- configurable address and data width (32- or 64-bit);
- a registered 1-cycle read port;
- correctly shifted, sign/zero-extended sub-word loads;
- misalignment and illegal-funct3 fault reporting;
- valid/ready backpressure on both request and response;
- a post-reset hardware zero-initialisation sweep.

## Interface
Parameters:
- ADDR_W, 9, byte-address width; capacity 2**ADDR_W bytes.
- DATA_W, 32, word width; legal values 32 or 64.
- Derived: NB = DATA_W/8 bytes per word, DEPTH = 2**ADDR_W / NB words.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high; clk and reset are the only clock/reset (one clock, synchronous active-high reset).
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request this cycle.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, DATA_W, store data; the operand is in the low bits, as from rs2.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, consumer accepts response.
- rsp_rdata, output, DATA_W, load result, right-aligned and extended; 0 for stores and faults.
- rsp_fault, output, 1, request was misaligned or illegal; no memory side effect.
- init_done, output, 1, high once the zeroing sweep has completed.

## Operation
- States:
  - INIT: entered on reset. Writes 0 to word init_cnt each cycle; init_cnt runs 0..DEPTH-1. After the write of word DEPTH-1, moves to RUN.
  - RUN: normal service.
- req_ready = (state==RUN) && (!rsp_valid || rsp_ready). Requests are ignored in INIT.
- A request is accepted on an edge where req_valid && req_ready. Exactly one response follows per accepted request.
- Word index = req_addr[ADDR_W-1:log2(NB)]; byte offset = low log2(NB) bits.
- Access sizes:
  - funct3[1:0] 00 = byte, 01 = half, 10 = word (32-bit), 11 = double.
  - Double is legal only when DATA_W=64.
  - funct3[2] = unsigned (loads only).
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101. When DATA_W=64, also 011 and 110.
  - Stores: 000, 001, 010. When DATA_W=64, also 011.
- Misaligned: the address is not a multiple of the access size. Misaligned or illegal requests produce rsp_fault=1 and rsp_rdata=0, and no memory write occurs.
- Stores:
  - Byte-lane write of req_wdata[size*8-1:0] into lanes [offset .. offset+size-1] of the addressed word.
  - Other lanes are unchanged.
  - The write commits on the acceptance edge.
- Loads:
  - Extract lanes [offset .. offset+size-1], shift to bit 0.
  - Sign-extend to DATA_W when funct3[2]=0; zero-extend when funct3[2]=1.
- Store response: rsp_valid with rsp_rdata=0, rsp_fault=0.
- Response register holds rsp_valid/rsp_rdata/rsp_fault stable until rsp_valid && rsp_ready. It is then cleared, or reloaded if a new request is accepted on the same edge.

## Timing
- Reset values:
  - state=INIT, init_cnt=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, init_done=0.
- The INIT sweep takes exactly DEPTH cycles after reset deasserts. init_done and req_ready (if no response is pending) rise on the following cycle.
- Load latency: request accepted at edge N; rsp_valid=1 with data after edge N, i.e. visible in cycle N+1.
- Throughput: one request per cycle when rsp_ready is held high.
- Store then load to the same word on consecutive accepted edges: the load returns the newly stored data.
- Backpressure: while rsp_valid && !rsp_ready, req_ready=0 and memory is untouched.
- Reset asserted mid-operation (including during INIT or with a response pending):
  - The pending response is dropped.
  - Any request presented on the reset edge is not accepted.
  - The INIT sweep restarts from word 0.

## Test plan
- Reset, then idle with ADDR_W=9, DATA_W=32 -> init_done rises after exactly 128 cycles; LW from 0x1FC returns 0x00000000 with rsp_fault=0.
- Sub-word loads:
  - Stimulus: SW 0x80F0_7F01 to 0x010, then LB/LBU at 0x011, 0x013 and LH/LHU at 0x012.
  - Required response: LB 0x011 -> 0x0000007F; LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080; LH 0x012 -> 0xFFFF80F0; LHU 0x012 -> 0x000080F0.
- Byte lanes:
  - Stimulus: SW 0xFFFFFFFF to 0x020, then SB 0x12 to 0x021, then SH 0xABCD to 0x022.
  - Required response: LW 0x020 returns 0xABCD12FF.
- Faults:
  - Stimulus: LW at 0x022, SH at 0x041, funct3=011 with DATA_W=32.
  - Required response: each returns rsp_fault=1, rsp_rdata=0; a following LW 0x040 shows the memory unchanged.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after accepting an LW.
  - Required response: rsp_rdata stays stable and req_ready stays 0. Raising rsp_ready completes the handshake, and back-to-back loads then complete one per cycle.
- DATA_W=64, ADDR_W=10:
  - Stimulus: SD 0x8000_0000_0000_0001 to 0x008, then LW 0x00C, LWU 0x00C, LD 0x008.
  - Required response: LW 0x00C -> 0xFFFFFFFF80000000; LWU 0x00C -> 0x0000000080000000; LD 0x008 -> the stored value.
  - Also: reset asserted mid-stream clears rsp_valid, and the sweep restarts (128 cycles).

Source files
------------

// File: rtl/dmem_handshake.sv
// dmem_handshake: byte-addressed data memory with valid/ready request and
// response channels, a registered one-cycle read, sub-word loads with sign or
// zero extension, misalignment / illegal-funct3 fault reporting, and a
// zeroing sweep after reset.
//
// Ports:
//   clk, reset          - sole clock; synchronous active-high reset
//   req_valid/req_ready - request handshake (ready is combinational)
//   req_we              - 1 = store, 0 = load
//   req_funct3          - RISC-V funct3: [1:0] size, [2] unsigned (loads)
//   req_addr            - byte address
//   req_wdata           - store operand, right-aligned
//   rsp_valid/rsp_ready - response handshake
//   rsp_rdata           - load result, right-aligned and extended
//   rsp_fault           - request was misaligned or illegal
//   init_done           - zeroing sweep has completed
module dmem_handshake #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              init_done
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LG_NB  = $clog2(NB);
  localparam int unsigned WIDX_W = ADDR_W - LG_NB;
  localparam int unsigned DEPTH  = (2 ** ADDR_W) / NB;
  localparam int unsigned SH_W   = LG_NB + 3;
  localparam bit          DBL_OK = (DATA_W == 64);

  typedef enum logic [0:0] {INIT, RUN} state_t;

  state_t              state;
  logic [WIDX_W-1:0]   init_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [LG_NB-1:0]    off;
  logic [WIDX_W-1:0]   widx;
  logic [1:0]          sz;
  logic                uns;
  logic                legal;
  logic [LG_NB-1:0]    amask;
  logic [NB-1:0]       be_sz;
  logic [NB-1:0]       be;
  logic [DATA_W-1:0]   vmask;
  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   wdata_sh;
  logic [DATA_W-1:0]   rsh;
  logic                sbit;
  logic [DATA_W-1:0]   ld_data;
  logic                fault;
  logic                accept;
  logic                store_we;

  assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready && !reset;
  assign store_we  = accept && req_we && !fault;

  // Request decode: legality, alignment, lane enables and load extraction
  always_comb begin
    off   = req_addr[LG_NB-1:0];
    widx  = req_addr[ADDR_W-1:LG_NB];
    sz    = req_funct3[1:0];
    uns   = req_funct3[2];
    amask = '0;
    be_sz = '0;
    vmask = '0;
    sbit  = 1'b0;

    // Loads: 111 never legal; 011/110 only with a 64-bit word
    if (req_we) begin
      legal = !uns && ((sz != 2'b11) || DBL_OK);
    end else begin
      legal = !(uns && (sz == 2'b11)) &&
              (((sz != 2'b11) && !(uns && (sz == 2'b10))) || DBL_OK);
    end

    sh       = {off, 3'b000};
    rsh      = mem[widx] >> sh;
    wdata_sh = req_wdata << sh;

    case (sz)
      2'b00: begin
        amask = '0;
        be_sz = NB'(1'b1);
        vmask = DATA_W'(8'hFF);
        sbit  = rsh[7];
      end
      2'b01: begin
        amask = LG_NB'(1);
        be_sz = NB'(2'b11);
        vmask = DATA_W'(16'hFFFF);
        sbit  = rsh[15];
      end
      2'b10: begin
        amask = LG_NB'(3);
        be_sz = NB'(4'hF);
        vmask = DATA_W'(32'hFFFF_FFFF);
        sbit  = rsh[31];
      end
      default: begin
        amask = LG_NB'(7);
        be_sz = '1;
        vmask = '1;
        sbit  = rsh[DATA_W-1];
      end
    endcase

    be      = be_sz << off;
    fault   = !legal || (|(off & amask));
    ld_data = (rsh & vmask) | ((!uns && sbit) ? ~vmask : '0);
  end

  // Storage: zeroing sweep during INIT, byte-lane stores during RUN
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else if (store_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Control FSM and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + WIDX_W'(1);
          if (init_cnt == WIDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault;
            rsp_rdata <= (fault || req_we) ? '0 : ld_data;
          end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_handshake.sv
// Bench for dmem_handshake: one 32-bit instance (ADDR_W=9) and one 64-bit
// instance (ADDR_W=10) sharing clock and reset. Expected responses are queued
// when a request is accepted and compared when the response handshakes.
module tb_dmem_handshake;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_fault;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    bit          fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        rv32, rr32, we32, sv32, sr32, sf32, id32;
  logic [2:0]  f332;
  logic [8:0]  addr32;
  logic [31:0] wd32, rd32;

  logic        rv64, rr64, we64, sv64, sr64, sf64, id64;
  logic [2:0]  f364;
  logic [9:0]  addr64;
  logic [63:0] wd64, rd64;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  exp_t q32[$];
  exp_t q64[$];
  vec_t t32[$];
  vec_t t64[$];

  dmem_handshake #(.ADDR_W(9), .DATA_W(32)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(rv32), .req_ready(rr32), .req_we(we32), .req_funct3(f332),
    .req_addr(addr32), .req_wdata(wd32),
    .rsp_valid(sv32), .rsp_ready(sr32), .rsp_rdata(rd32), .rsp_fault(sf32),
    .init_done(id32)
  );

  dmem_handshake #(.ADDR_W(10), .DATA_W(64)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(rv64), .req_ready(rr64), .req_we(we64), .req_funct3(f364),
    .req_addr(addr64), .req_wdata(wd64),
    .rsp_valid(sv64), .rsp_ready(sr64), .rsp_rdata(rd64), .rsp_fault(sf64),
    .init_done(id64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit we, input logic [2:0] f3, input logic [9:0] a,
                              input logic [63:0] wd, input logic [63:0] er, input bit ef);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_fault = ef;
    return v;
  endfunction

  // Response scoreboards: a handshake happens on the edge following this sample
  always @(negedge clk) begin
    if (!reset && sv32 && sr32) begin
      if (q32.size() == 0) check("rsp32_unexpected", 64'(1), 64'(0));
      else begin
        exp_t e;
        e = q32.pop_front();
        check("rsp32_rdata", 64'(rd32), e.rdata);
        check("rsp32_fault", 64'(sf32), 64'(e.fault));
      end
    end
    if (!reset && sv64 && sr64) begin
      if (q64.size() == 0) check("rsp64_unexpected", 64'(1), 64'(0));
      else begin
        exp_t e;
        e = q64.pop_front();
        check("rsp64_rdata", rd64, e.rdata);
        check("rsp64_fault", 64'(sf64), 64'(e.fault));
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, queue its expectation
  task automatic issue(input bit w64, input vec_t v);
    int   waitc = 0;
    bit   acc   = 0;
    exp_t e;
    if (w64) begin
      rv64 = 1'b1; we64 = v.we; f364 = v.f3; addr64 = v.addr; wd64 = v.wdata;
    end else begin
      rv32 = 1'b1; we32 = v.we; f332 = v.f3; addr32 = v.addr[8:0]; wd32 = v.wdata[31:0];
    end
    while (!acc && waitc < 50) begin
      @(negedge clk);
      if (w64 ? rr64 : rr32) acc = 1;
      else waitc++;
    end
    check(w64 ? "issue64_accept" : "issue32_accept", 64'(acc), 64'(1));
    if (acc) begin
      e.rdata = v.exp_rdata;
      e.fault = v.exp_fault;
      if (w64) q64.push_back(e);
      else q32.push_back(e);
    end
    @(posedge clk);
    #1;
    if (w64) rv64 = 1'b0;
    else rv32 = 1'b0;
  endtask

  // Count cycles from reset release until each instance reports init_done
  task automatic sweep();
    int cnt = 0;
    int c32 = 0;
    int c64 = 0;
    while (!(id32 && id64) && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (id32 && c32 == 0) begin
        c32 = cnt;
        check("req_ready32_after_init", 64'(rr32), 64'(1));
      end
      if (id64 && c64 == 0) c64 = cnt;
    end
    check("sweep32_cycles", 64'(c32), 64'(128));
    check("sweep64_cycles", 64'(c64), 64'(128));
  endtask

  task automatic drain();
    int waitc = 0;
    while ((q32.size() != 0 || q64.size() != 0) && waitc < 50) begin
      @(posedge clk);
      waitc++;
    end
    #1;
    check("drain_q32", 64'(q32.size()), 64'(0));
    check("drain_q64", 64'(q64.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1;
    rv32 = 0; we32 = 0; f332 = 0; addr32 = 0; wd32 = 0; sr32 = 1;
    rv64 = 0; we64 = 0; f364 = 0; addr64 = 0; wd64 = 0; sr64 = 1;

    // 32-bit vectors: {we, funct3, addr, wdata, expected rdata, expected fault}
    t32.push_back(mk(0, 3'b010, 10'h1FC, 64'h0,          64'h0,          0)); // LW swept word
    t32.push_back(mk(1, 3'b010, 10'h010, 64'h80F07F01,   64'h0,          0)); // SW
    t32.push_back(mk(0, 3'b000, 10'h011, 64'h0,          64'h0000007F,   0)); // LB
    t32.push_back(mk(0, 3'b000, 10'h013, 64'h0,          64'hFFFFFF80,   0)); // LB
    t32.push_back(mk(0, 3'b100, 10'h013, 64'h0,          64'h00000080,   0)); // LBU
    t32.push_back(mk(0, 3'b001, 10'h012, 64'h0,          64'hFFFF80F0,   0)); // LH
    t32.push_back(mk(0, 3'b101, 10'h012, 64'h0,          64'h000080F0,   0)); // LHU
    t32.push_back(mk(1, 3'b010, 10'h020, 64'hFFFFFFFF,   64'h0,          0)); // SW
    t32.push_back(mk(1, 3'b000, 10'h021, 64'hA5A5A512,   64'h0,          0)); // SB
    t32.push_back(mk(1, 3'b001, 10'h022, 64'h5A5AABCD,   64'h0,          0)); // SH
    t32.push_back(mk(0, 3'b010, 10'h020, 64'h0,          64'hABCD12FF,   0)); // LW
    t32.push_back(mk(1, 3'b010, 10'h040, 64'h11223344,   64'h0,          0)); // SW
    t32.push_back(mk(0, 3'b010, 10'h022, 64'h0,          64'h0,          1)); // LW misaligned
    t32.push_back(mk(1, 3'b001, 10'h041, 64'hFFFF,       64'h0,          1)); // SH misaligned
    t32.push_back(mk(0, 3'b011, 10'h040, 64'h0,          64'h0,          1)); // LD illegal
    t32.push_back(mk(1, 3'b011, 10'h040, 64'hFFFFFFFF,   64'h0,          1)); // SD illegal
    t32.push_back(mk(0, 3'b111, 10'h040, 64'h0,          64'h0,          1)); // 111 illegal
    t32.push_back(mk(1, 3'b100, 10'h040, 64'hFFFFFFFF,   64'h0,          1)); // store 100 illegal
    t32.push_back(mk(0, 3'b110, 10'h040, 64'h0,          64'h0,          1)); // LWU illegal
    t32.push_back(mk(0, 3'b010, 10'h040, 64'h0,          64'h11223344,   0)); // unchanged

    t64.push_back(mk(1, 3'b011, 10'h008, 64'h8000000000000001, 64'h0,                0));
    t64.push_back(mk(0, 3'b010, 10'h00C, 64'h0, 64'hFFFFFFFF80000000, 0)); // LW
    t64.push_back(mk(0, 3'b110, 10'h00C, 64'h0, 64'h0000000080000000, 0)); // LWU
    t64.push_back(mk(0, 3'b011, 10'h008, 64'h0, 64'h8000000000000001, 0)); // LD
    t64.push_back(mk(0, 3'b011, 10'h00C, 64'h0, 64'h0,                1)); // LD misaligned
    t64.push_back(mk(0, 3'b100, 10'h00F, 64'h0, 64'h0000000000000080, 0)); // LBU
    t64.push_back(mk(0, 3'b001, 10'h00E, 64'h0, 64'hFFFFFFFFFFFF8000, 0)); // LH
    t64.push_back(mk(0, 3'b111, 10'h008, 64'h0, 64'h0,                1)); // 111 illegal

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready32", 64'(rr32), 64'(0));
    check("rst_rsp_valid32", 64'(sv32), 64'(0));
    check("rst_rsp_rdata32", 64'(rd32), 64'(0));
    check("rst_rsp_fault32", 64'(sf32), 64'(0));
    check("rst_init_done32", 64'(id32), 64'(0));
    check("rst_req_ready64", 64'(rr64), 64'(0));
    check("rst_init_done64", 64'(id64), 64'(0));
    reset = 1'b0;
    sweep();

    foreach (t32[i]) issue(0, t32[i]);
    drain();

    // Backpressure: response held, a competing store must not be accepted
    sr32 = 1'b0;
    issue(0, mk(0, 3'b010, 10'h020, 64'h0, 64'hABCD12FF, 0));
    rv32 = 1'b1; we32 = 1'b1; f332 = 3'b010; addr32 = 9'h020; wd32 = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(sv32), 64'(1));
      check("bp_rsp_rdata", 64'(rd32), 64'hABCD12FF);
      check("bp_req_ready", 64'(rr32), 64'(0));
    end
    @(posedge clk);
    #1;
    rv32 = 1'b0;
    sr32 = 1'b1;
    c0 = cyc;
    issue(0, mk(0, 3'b010, 10'h020, 64'h0, 64'hABCD12FF, 0));
    issue(0, mk(0, 3'b010, 10'h010, 64'h0, 64'h80F07F01, 0));
    issue(0, mk(0, 3'b000, 10'h011, 64'h0, 64'h0000007F, 0));
    issue(0, mk(0, 3'b010, 10'h040, 64'h0, 64'h11223344, 0));
    check("b2b_cycles", 64'(cyc - c0), 64'(4));
    drain();

    foreach (t64[i]) issue(1, t64[i]);
    drain();

    // Reset with a response pending and a request presented on the reset edge
    sr64 = 1'b0;
    issue(1, mk(0, 3'b011, 10'h008, 64'h0, 64'h8000000000000001, 0));
    reset = 1'b1;
    sr64  = 1'b1;
    rv64 = 1'b1; we64 = 1'b1; f364 = 3'b011; addr64 = 10'h010; wd64 = 64'h1234;
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;
    check("midrst_rsp_valid64", 64'(sv64), 64'(0));
    check("midrst_req_ready64", 64'(rr64), 64'(0));
    check("midrst_init_done64", 64'(id64), 64'(0));
    check("midrst_rsp_valid32", 64'(sv32), 64'(0));
    rv64  = 1'b0;
    reset = 1'b0;
    sweep();
    issue(1, mk(0, 3'b011, 10'h008, 64'h0, 64'h0, 0));
    issue(0, mk(0, 3'b010, 10'h020, 64'h0, 64'h0, 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
